// File: rtl/counter_bist.sv
// Self-test sequencer for a WIDTH-bit up/down counter: load, count up, hold, count down, compare every cycle.
// Run takes 1+2*(2^WIDTH+1)+HOLD_LEN drive cycles; done on the following edge; start ignored while busy.
module counter_bist #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'('hE),
  parameter int               HOLD_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic             load_n,
  output logic             ce,
  output logic             up_down,
  output logic [WIDTH-1:0] data_load,
  input  logic [WIDTH-1:0] count_out,
  input  logic             max_count,
  input  logic             zero
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, HOLD, DOWN, DRAIN, DONE} state_t;

  localparam int PW = (WIDTH + 2 > $clog2(HOLD_LEN + 1) + 1) ? WIDTH + 2 : $clog2(HOLD_LEN + 1) + 1;
  localparam logic [PW-1:0] RUN_LAST  = PW'(2 ** WIDTH);
  localparam logic [PW-1:0] HOLD_LAST = PW'(HOLD_LEN - 1);

  state_t           state, next;
  logic [PW-1:0]    phase, phase_next;
  logic [WIDTH-1:0] exp_val;
  logic             cmp_en;
  logic             accept;
  logic             mismatch;
  logic [7:0]       err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= next;
      phase <= phase_next;
    end
  end

  // Phase counter holds remaining cycles minus one; reloaded whenever a new state is entered.
  always_comb begin
    next       = state;
    phase_next = (phase == '0) ? '0 : phase - PW'(1);
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next   = LOAD;
          accept = 1'b1;
        end
      end
      LOAD:    next = UP;
      UP:      if (phase == '0) next = HOLD;
      HOLD:    if (phase == '0) next = DOWN;
      DOWN:    if (phase == '0) next = DRAIN;
      DRAIN:   next = DONE;
      default: next = IDLE;
    endcase
    if (next != state) begin
      case (next)
        UP:      phase_next = RUN_LAST;
        HOLD:    phase_next = HOLD_LAST;
        DOWN:    phase_next = RUN_LAST;
        default: phase_next = '0;
      endcase
    end
  end

  always_comb begin
    mismatch = (count_out != exp_val) |
               (max_count != (exp_val == '1)) |
               (zero != (exp_val == '0));
    err_next = err_count;
    if (cmp_en && mismatch && (err_count != 8'hFF))
      err_next = err_count + 8'd1;
  end

  // Control outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_n    <= 1'b1;
      ce        <= 1'b0;
      up_down   <= 1'b0;
      data_load <= '0;
      busy      <= 1'b0;
    end else begin
      load_n    <= (next != LOAD);
      ce        <= (next == UP) || (next == DOWN);
      up_down   <= (next == UP);
      data_load <= (next == LOAD) ? SEED : '0;
      busy      <= (next != IDLE) && (next != DONE);
    end
  end

  // The model advances on the same edge at which the counter samples the registered controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_val <= '0;
      cmp_en  <= 1'b0;
    end else begin
      if (!load_n) begin
        exp_val <= SEED;
        cmp_en  <= 1'b1;
      end else begin
        if (ce)
          exp_val <= up_down ? exp_val + WIDTH'(1) : exp_val - WIDTH'(1);
        if (state == DRAIN)
          cmp_en <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (accept) begin
      err_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      err_count <= err_next;
      if (state == DRAIN) begin
        done <= 1'b1;
        pass <= (err_next == 8'd0);
      end
    end
  end

endmodule

// File: doc/counter_bist.md
# counter_bist

Synthesizable self-test sequencer for the 4-bit up/down counter with load and count-enable. Drives the counter's control inputs (`load_n`, `ce`, `up_down`, `data_load`) through a fixed load/up/hold/down program. Tracks the expected count with an internal model and compares `count_out`, `max_count` and `zero` every cycle. Reports pass/fail and an error count. Sits beside the counter in the test wrapper and shares its clock and reset.

## Interface
- `WIDTH`, 4: counter width.
- `SEED`, 4'hE: value loaded at the start of a run, `WIDTH` bits.
- `HOLD_LEN`, 3: number of cycles with `ce`=0 between the up and down phases, ≥1.

- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low
- `start`  in  1  pulse that starts a run; sampled only when not busy
- `busy`  out  1  run in progress
- `done`  out  1  run finished; held until the next accepted `start`
- `pass`  out  1  `done` && `err_count`==0
- `err_count`  out  8  mismatching compare cycles, saturating at 255
- `load_n`  out  1  to counter, active-low load
- `ce`  out  1  to counter, count enable
- `up_down`  out  1  to counter, 1 = up
- `data_load`  out  WIDTH  to counter, load value
- `count_out`  in  WIDTH  from counter
- `max_count`  in  1  from counter
- `zero`  in  1  from counter

## Operation
- All outputs are registered.
- Reset values:
  - `load_n`=1, `ce`=0, `up_down`=0, `data_load`=0.
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0.
  - FSM in IDLE, model `exp`=0, compare disabled.
- FSM states and transitions:
  - IDLE: on `start`, clear `err_count` and `done`, then go to LOAD.
  - LOAD: 1 cycle, `load_n`=0, `data_load`=SEED.
  - UP: 2^WIDTH+1 cycles, `ce`=1, `up_down`=1.
  - HOLD: HOLD_LEN cycles, `ce`=0.
  - DOWN: 2^WIDTH+1 cycles, `ce`=1, `up_down`=0.
  - DRAIN: 1 cycle, controls idle; the last compare is registered here.
  - DONE: `done`=1, `busy`=0; return to IDLE behaviour and accept `start`.
- Idle control values (every state other than LOAD): `load_n`=1, `data_load`=0.
- A phase-length counter is reloaded on each state entry.
- Model `exp` updates on the same edge at which the counter samples the driven registers:
  - load: `exp` ← SEED;
  - ce=1, up: `exp` ← `exp`+1 mod 2^WIDTH;
  - ce=1, down: `exp` ← `exp`−1 mod 2^WIDTH;
  - otherwise `exp` holds.
- Compare enable: set on the edge the load takes effect; cleared when DRAIN exits.
- Compare, evaluated while enabled:
  - mismatch = (`count_out`≠`exp`) | (`max_count`≠(`exp`==all ones)) | (`zero`≠(`exp`==0)).
  - Each mismatching cycle adds exactly 1 to `err_count`, regardless of how many fields differ.
- Boundaries:
  - `start` while busy: ignored.
  - `start` in the same cycle `done` would rise: ignored.
  - Wrap-around F→0 and 0→F is exercised and modelled modulo 2^WIDTH.
  - `err_count` stops at 255.
  - `rst_n` low mid-run: immediate return to reset values and the run is abandoned; a new `start` is needed after release.

## Timing
- Edge 0 = the edge that samples `start`.
- `busy` rises on edge 0. `load_n`=0 is driven from edge 0 to edge 1.
- The counter loads on edge 1. The first compare is registered on edge 2.
- Drive cycles D = 1 + 2(2^WIDTH+1) + HOLD_LEN; D = 38 for the defaults.
- Compare cycles = D = 38.
- The last counter update is on edge D.
- `done`/`pass` rise and `busy` falls on edge D+1 = 39.
- The next `start` is accepted from edge D+1 onward (sampled on edge ≥ D+2).

## Test plan
- Correct counter, defaults, pulse `start` → `busy` for 39 cycles, then `done`=1, `pass`=1, `err_count`=0. Driven sequence is 1 load, 17 up, 3 hold, 17 down.
- `max_count` stuck at 0 → `err_count`=6. `exp`=F occurs 2× in UP, 3× in HOLD, 1× in DOWN. `pass`=0.
- `zero` stuck at 0 → `err_count`=2 (one in UP, one in DOWN).
- `count_out[0]` stuck at 0 → `err_count` equals the number of compare cycles with `exp` odd, which is 20 of 38. `pass`=0.
- Assert `rst_n` low during UP (cycle 10), then release → all outputs at reset values, and no `done` appears. A fresh `start` then completes with `pass`=1 at +39 cycles.
- `start` pulsed during busy and again on edge 39 → both ignored. A `start` on edge 41 begins a new run; `err_count` is cleared on acceptance.
